// File: rtl/stdp_scheduler.sv
// STDP learning controller: per-synapse pre/post timers feed a round-robin, 3-state shared weight-update sequencer.
// Define STDP_LTD_EN to build the depression path; without it pre spikes only reset timers and weights only grow.
module stdp_scheduler #(
  parameter int         N_SYN  = 4,
  parameter logic [7:0] W_INIT = 8'd16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SYN-1:0]         pre_spike,
  input  logic [N_SYN-1:0]         post_spike,
  input  logic                     learn_en,
  input  logic [$clog2(N_SYN)-1:0] rd_sel,
  output logic [7:0]               rd_weight,
  output logic                     busy,
  output logic                     upd_valid,
  output logic [$clog2(N_SYN)-1:0] upd_idx,
  output logic                     upd_ltp,
  output logic [7:0]               upd_weight
);
  localparam int IW = $clog2(N_SYN);
  localparam logic [IW-1:0] LAST = IW'(N_SYN - 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
  state_t state;

  logic [7:0]       weight  [N_SYN];
  logic [7:0]       pre_t   [N_SYN];
  logic [N_SYN-1:0] pend_vld;
  logic [4:0]       pend_dt [N_SYN];
  logic [N_SYN-1:0] ev_vld;
  logic [4:0]       ev_dt   [N_SYN];
  logic [IW-1:0]    rr_ptr, cur_idx, gnt_idx;
  logic [4:0]       cur_dt;
  logic             gnt_vld;
  logic [7:0]       delta, new_w;
  logic [8:0]       sum;
`ifdef STDP_LTD_EN
  logic [7:0]       post_t  [N_SYN];
  logic [N_SYN-1:0] pend_ltp, ev_ltp;
  logic             cur_ltp;
  logic [8:0]       diff;
`endif

  // Event capture uses the timer values from before this edge's update.
  always_comb begin
    for (int i = 0; i < N_SYN; i++) begin
      ev_vld[i] = 1'b0;
      ev_dt[i]  = 5'd0;
`ifdef STDP_LTD_EN
      ev_ltp[i] = 1'b1;
`endif
      if (learn_en) begin
        if (post_spike[i] && pre_spike[i]) begin
          ev_vld[i] = 1'b1;
        end else if (post_spike[i] && pre_t[i] < 8'd32) begin
          ev_vld[i] = 1'b1;
          ev_dt[i]  = pre_t[i][4:0];
        end
`ifdef STDP_LTD_EN
        else if (pre_spike[i] && post_t[i] < 8'd32) begin
          ev_vld[i] = 1'b1;
          ev_ltp[i] = 1'b0;
          ev_dt[i]  = post_t[i][4:0];
        end
`endif
      end
    end
  end

  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_SYN - 1; k >= 0; k--) begin
      if (pend_vld[(int'(rr_ptr) + k) % N_SYN]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'((int'(rr_ptr) + k) % N_SYN);
      end
    end
  end

  always_comb begin
    if (cur_dt < 5'd4)       delta = 8'd8;
    else if (cur_dt < 5'd8)  delta = 8'd4;
    else if (cur_dt < 5'd16) delta = 8'd2;
    else                     delta = 8'd1;
    sum   = {1'b0, weight[cur_idx]} + {1'b0, delta};
    new_w = sum[8] ? 8'hFF : sum[7:0];
`ifdef STDP_LTD_EN
    diff  = {1'b0, weight[cur_idx]} - {1'b0, delta};
    if (!cur_ltp) new_w = diff[8] ? 8'h00 : diff[7:0];
`endif
  end

  assign rd_weight = (int'(rd_sel) < N_SYN) ? weight[rd_sel] : 8'd0;
`ifndef STDP_LTD_EN
  assign upd_ltp = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_weight <= 8'd0;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      cur_dt     <= 5'd0;
      pend_vld   <= '0;
      for (int i = 0; i < N_SYN; i++) begin
        weight[i]  <= W_INIT;
        pre_t[i]   <= 8'hFF;
        pend_dt[i] <= 5'd0;
`ifdef STDP_LTD_EN
        post_t[i]  <= 8'hFF;
`endif
      end
`ifdef STDP_LTD_EN
      pend_ltp <= '0;
      cur_ltp  <= 1'b0;
      upd_ltp  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N_SYN; i++) begin
        pre_t[i] <= pre_spike[i] ? 8'd0 : ((pre_t[i] == 8'hFF) ? 8'hFF : pre_t[i] + 8'd1);
`ifdef STDP_LTD_EN
        post_t[i] <= post_spike[i] ? 8'd0 : ((post_t[i] == 8'hFF) ? 8'hFF : post_t[i] + 8'd1);
`endif
        // A fresh event on the grant edge re-arms the slot instead of being lost.
        if (ev_vld[i]) begin
          pend_vld[i] <= 1'b1;
          pend_dt[i]  <= ev_dt[i];
`ifdef STDP_LTD_EN
          pend_ltp[i] <= ev_ltp[i];
`endif
        end else if (state == IDLE && gnt_vld && gnt_idx == IW'(i)) begin
          pend_vld[i] <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (gnt_vld) begin
            state   <= CALC;
            busy    <= 1'b1;
            cur_idx <= gnt_idx;
            cur_dt  <= pend_dt[gnt_idx];
`ifdef STDP_LTD_EN
            cur_ltp <= pend_ltp[gnt_idx];
`endif
            rr_ptr  <= (gnt_idx == LAST) ? '0 : gnt_idx + IW'(1);
          end
        end
        CALC: begin
          weight[cur_idx] <= new_w;
          upd_valid       <= 1'b1;
          upd_idx         <= cur_idx;
          upd_weight      <= new_w;
`ifdef STDP_LTD_EN
          upd_ltp         <= cur_ltp;
`endif
          state           <= WRITE;
        end
        WRITE: begin
          upd_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/stdp_scheduler.md
# stdp_scheduler

Time-multiplexed STDP learning controller for N_SYN synapses sharing one weight-update datapath. It keeps per-synapse pre/post spike timers, turns spike events into pending update requests, and grants them round-robin to a single 3-state update sequencer. The sequencer computes a time-difference-based delta and writes the saturated result into an internal 8-bit weight file. It sits between the spike sources and the neuron array, which reads weights through `rd_sel`/`rd_weight`.

## Interface
- `N_SYN`, 4: number of synapses (2..16)
- `W_INIT`, 8'd16: weight value loaded on reset
- `clk` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `pre_spike` in N_SYN: per-synapse pre-synaptic spike, sampled each edge
- `post_spike` in N_SYN: per-synapse post-synaptic spike, sampled each edge
- `learn_en` in 1: when low, no new requests are queued
- `rd_sel` in $clog2(N_SYN): weight read index
- `rd_weight` out 8: combinational read of `weight[rd_sel]`
- `busy` out 1: high when the FSM is not in IDLE
- `upd_valid` out 1: one-cycle pulse per completed update
- `upd_idx` out $clog2(N_SYN): synapse updated
- `upd_ltp` out 1: 1 = potentiation, 0 = depression
- `upd_weight` out 8: new weight written

## Operation
- Timers: per synapse, `pre_t`/`post_t` are 8 bits; they clear to 0 on their own spike, otherwise increment and saturate at 255. No wrap.
- Request capture (learn_en=1): a post spike queues LTP with dt = `post`-side view `pre_t`. A pre spike queues LTD with dt = `post_t`. Both values are taken before this edge's timer update.
- Only dt < 32 queues a request. dt ≥ 32 is dropped.
- Each synapse has one pending slot holding `kind` and `dt`. A new event overwrites an ungranted pending request (latest wins).
- Simultaneous pre+post on the same synapse: LTP with dt=0 only.
- Delta LUT: dt 0–3 → 8, 4–7 → 4, 8–15 → 2, 16–31 → 1.
- Weight arithmetic: LTP w = min(w+delta, 255). LTD w = max(w−delta, 0). Uses a 9-bit intermediate.
- Arbiter: round-robin. Search starts at `rr_ptr`, lowest index first. On grant, `rr_ptr` = granted index + 1 (mod N_SYN).
- FSM states:
  - IDLE: on any pending, latch idx/kind/dt and clear that slot, then go to CALC. If a new event for the same synapse arrives on the grant edge, it stays pending.
  - CALC: write the new weight into the file, register the `upd_*` outputs, then go to WRITE.
  - WRITE: `upd_valid`=1 for this cycle, then go to IDLE.
- `learn_en` low: timers still run; requests already pending or in flight complete.

## Timing
- Reset values: all weights = W_INIT, timers = 255, pending = 0, `rr_ptr` = 0, FSM = IDLE, `busy`=0, `upd_valid`=0, `upd_idx`=0, `upd_ltp`=0, `upd_weight`=0.
- Spike sampled at edge E0 → pending visible after E0 → grant at E1 → weight written at E2 → `upd_valid` high during the cycle after E2.
- Spike-to-`upd_valid` latency is 3 edges when idle. Throughput is one update per 3 cycles.
- `rd_weight` reflects a new weight in the cycle after E2, the same cycle `upd_valid` is high.
- Reset mid-operation discards the in-flight update: the weight is not written and no `upd_valid` is produced.

## Configuration
- `STDP_LTD_EN` defined: pre spikes queue LTD requests as described above.
- `STDP_LTD_EN` undefined:
  - pre spikes only clear `pre_t`;
  - no LTD requests are queued;
  - the depression path is not built;
  - `upd_ltp` is always 1;
  - weights never decrease.

## Test plan
- Reset, then pre on syn0 at cycle 0 and post on syn0 at cycle 5 → LTP dt=4, delta 4; `upd_valid` 3 edges after the post edge; `upd_idx`=0, `upd_weight`=20.
- Post spikes on syn1 and syn2 in the same cycle, `rr_ptr`=0 → syn1 is updated first, syn2 3 cycles later; `rr_ptr` ends at 3.
- Set syn3 weight near 255 with repeated dt=0 pairs → weight saturates at 255 and never wraps; with LTD from weight 3 and delta 8 (dt=0) → weight becomes 0.
- No spikes for 300 cycles, then post on syn0 → timer saturated at 255, dt ≥ 32, no request, `upd_valid` stays 0.
- `learn_en`=0 with spikes present → no updates; timers are still cleared by spikes. Pre+post in the same cycle with `learn_en`=1 → a single LTP with dt=0.
- Assert `reset` during CALC → weight unchanged at W_INIT, no `upd_valid`, FSM returns to IDLE. Repeat the pre-then-post scenario with `STDP_LTD_EN` undefined → only LTP updates occur.
